// File: rtl/hbridge_seq_pkg.sv
// hbridge_pkg: shared state encoding and PWM divider helper for the H-bridge sequencer
package hbridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DEAD    = 3'd2,
        FAULT   = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // Prescaler length so that 256 PWM steps span one PWM period; never below one clock
    function automatic int tick_div(input int clk_hz, input int pwm_hz);
        int d;
        d = clk_hz / (pwm_hz * 256);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/hbridge_seq_if.sv
// hbridge_seq_if: command, current-sense and bridge-pin bundle around the H-bridge sequencer
interface hbridge_seq_if;
    import hbridge_pkg::*;

    logic       run;
    logic       dir;
    logic [7:0] duty;
    logic       oc_n;
    logic       clr_fault;
    logic [1:0] hb_en;
    logic [3:0] hb_in;
    logic       fault;
    logic       lockout;
    state_t     state;

    modport master (
        output run, dir, duty, oc_n, clr_fault,
        input  hb_en, hb_in, fault, lockout, state
    );

    modport slave (
        input  run, dir, duty, oc_n, clr_fault,
        output hb_en, hb_in, fault, lockout, state
    );

endinterface

// File: rtl/hbridge_seq_pwm_gen.sv
// pwm_gen: 256-step PWM with prescaler, period-boundary strobe and glitch-free duty/dir latch
module pwm_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic [7:0] duty_in,
    input  logic       dir_in,
    output logic       boundary,
    output logic       pwm_nx,
    output logic       dir_nx,
    output logic       dir_l
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    step_q, step_d;
    logic [7:0]    duty_q, duty_d;
    logic          dir_q, dir_d;
    logic          tick;

    // Boundary depends only on registers so the FSM can use it without a combinational loop
    assign tick     = pre_q == PW'(TICK_DIV - 1);
    assign boundary = tick && step_q == 8'hff;
    assign dir_l    = dir_q;
    assign dir_nx   = dir_d;

    // Advance counters; duty/dir only change at a period edge or on a restart; pwm_nx is next cycle's level
    always_comb begin
        pre_d  = (restart || tick) ? '0 : pre_q + 1'b1;
        step_d = restart ? 8'd0 : step_q + {7'd0, tick};
        duty_d = (restart || boundary) ? duty_in : duty_q;
        dir_d  = (restart || boundary) ? dir_in : dir_q;
        pwm_nx = step_d < duty_d;
    end

    // Counter and latch registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            step_q <= 8'd0;
            duty_q <= 8'd0;
            dir_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            step_q <= step_d;
            duty_q <= duty_d;
            dir_q  <= dir_d;
        end
    end

endmodule

// File: rtl/hbridge_seq.sv
// hbridge_seq: dual H-bridge sequencer with PWM, reversal dead-time and over-current retry/lockout
module hbridge_seq
    import hbridge_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int PWM_HZ    = 1000,
    parameter int DEAD_CYC  = 1000,
    parameter int OC_FILT   = 16,
    parameter int COOL_CYC  = 10_000_000,
    parameter int MAX_RETRY = 3
) (
    input logic          clk,
    input logic          rst,
    hbridge_seq_if.slave bus
);

    localparam int TICK_DIV = tick_div(CLK_HZ, PWM_HZ);
    localparam int CNT_MAX  = (DEAD_CYC > COOL_CYC) ? DEAD_CYC : COOL_CYC;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int FW       = $clog2(OC_FILT + 1);
    localparam int RW       = $clog2(MAX_RETRY + 2);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    clean_q, clean_d;
    logic [1:0]    sync_q, sync_d;
    logic [1:0]    hb_en_q, hb_en_d;
    logic [3:0]    hb_in_q, hb_in_d;
    logic          fault_q, fault_d;
    logic          lockout_q, lockout_d;
    logic          oc_hit, restart, boundary, pwm_nx, dir_nx, dir_l, fault_entry;

    pwm_gen #(.TICK_DIV(TICK_DIV)) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .duty_in  (bus.duty),
        .dir_in   (bus.dir),
        .boundary (boundary),
        .pwm_nx   (pwm_nx),
        .dir_nx   (dir_nx),
        .dir_l    (dir_l)
    );

    // Next state: over-current beats a stop request, which beats a direction change
    always_comb begin
        oc_hit  = filt_q == FW'(OC_FILT);
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (oc_hit)
                    state_d = FAULT;
                else if (!bus.run)
                    state_d = IDLE;
                else if (boundary && bus.dir != dir_l)
                    state_d = DEAD;
            end
            DEAD: begin
                if (oc_hit)
                    state_d = FAULT;
                else if (!bus.run)
                    state_d = IDLE;
                else if (cnt_q == CW'(DEAD_CYC - 1)) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            FAULT: begin
                if (retry_q > RW'(MAX_RETRY))
                    state_d = LOCKOUT;
                else if (cnt_q == CW'(COOL_CYC - 1))
                    state_d = IDLE;
            end
            LOCKOUT: begin
                if (bus.clr_fault && !bus.run)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Filter, timers, retry bookkeeping and next output values derived from the next state
    always_comb begin
        sync_d      = {sync_q[0], bus.oc_n};
        filt_d      = sync_q[1] ? '0 : oc_hit ? filt_q : filt_q + 1'b1;
        cnt_d       = (state_d != state_q || (state_q != DEAD && state_q != FAULT)) ? '0 : cnt_q + 1'b1;
        fault_entry = state_d == FAULT && state_q != FAULT;
        clean_d     = fault_entry ? 8'd0 : clean_q + {7'd0, state_q == RUN && boundary};
        retry_d     = fault_entry ? retry_q + 1'b1
                    : ((state_q == RUN && boundary && clean_q == 8'hff) ||
                       (state_q == LOCKOUT && state_d == IDLE)) ? '0 : retry_q;
        hb_en_d     = (state_d == RUN || state_d == DEAD) ? 2'b11 : 2'b00;
        hb_in_d     = (state_d != RUN) ? 4'b0000
                    : dir_nx ? {pwm_nx, 1'b0, pwm_nx, 1'b0} : {1'b0, pwm_nx, 1'b0, pwm_nx};
        fault_d     = state_d == FAULT || state_d == LOCKOUT;
        lockout_d   = state_d == LOCKOUT;
    end

    // State and output registers; reset drops every bridge pin at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            filt_q    <= '0;
            retry_q   <= '0;
            clean_q   <= 8'd0;
            sync_q    <= 2'b11;
            hb_en_q   <= 2'b00;
            hb_in_q   <= 4'b0000;
            fault_q   <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            retry_q   <= retry_d;
            clean_q   <= clean_d;
            sync_q    <= sync_d;
            hb_en_q   <= hb_en_d;
            hb_in_q   <= hb_in_d;
            fault_q   <= fault_d;
            lockout_q <= lockout_d;
        end
    end

    assign bus.hb_en   = hb_en_q;
    assign bus.hb_in   = hb_in_q;
    assign bus.fault   = fault_q;
    assign bus.lockout = lockout_q;
    assign bus.state   = state_q;

endmodule
